instr_fetch_unit: RTL and testbench

Front end of the pipeline, directly upstream of the two-level `Memory` wrapper's instruction port. Owns the PC and issues word reads on `MEM_RDEN1`/`MEM_ADDR1`, holding the address stable through L1 misses until `memValid1`. Buffers returned instructions in a small FIFO toward decode with a valid/ready handshake. Handles branch/jump redirects, including a redirect that arrives while a miss refill is in flight.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [2:0] {RESET, FETCH, MISS, DRAIN, FAULT} fetch_state_t;

    localparam logic [31:0] IMEM_LIMIT = 32'h6000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // A PC outside instruction memory or not word aligned halts fetch.
    function automatic logic pc_illegal(input logic [31:0] pc);
        return (pc >= IMEM_LIMIT) || (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer between fetch and decode; flush wins over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem_reg [DEPTH];
    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic [PW:0]    count_reg;
    logic           do_push;
    logic           do_pop;

    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign head    = mem_reg[rd_ptr_reg];

    // Storage is cleared on reset so the head output never carries X.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC owner and instruction fetcher: holds the read address through cache misses
// and drains an in-flight refill before honouring a redirect taken during a miss.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PC_LOAD,
    input  logic [31:0] PC_TARGET,
    input  logic        ID_READY,
    output logic        IF_VALID,
    output logic [31:0] IF_INSTR,
    output logic [31:0] IF_PC,
    output logic        IF_FAULT,
    output logic        MEM_RDEN1,
    output logic [13:0] MEM_ADDR1,
    input  logic [31:0] MEM_DOUT1,
    input  logic        memValid1
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  target_reg, target_next;
    logic         illegal;
    logic         full;
    logic         empty;
    logic         push;
    logic         flush;
    fetch_entry_t head;

    assign illegal   = pc_illegal(pc_reg);
    assign MEM_ADDR1 = pc_reg[15:2];
    assign MEM_RDEN1 = ((state_reg == FETCH) & ~full & ~illegal)
                     | (state_reg == MISS) | (state_reg == DRAIN);
    assign IF_FAULT  = (state_reg == FAULT);
    assign IF_VALID  = ~empty;
    assign IF_PC     = head.pc;
    assign IF_INSTR  = head.instr;

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        target_next = target_reg;
        push        = 1'b0;
        flush       = 1'b0;
        case (state_reg)
            RESET: state_next = FETCH;
            FETCH: begin
                if (PC_LOAD) begin
                    flush   = 1'b1;
                    pc_next = PC_TARGET;
                end else if (illegal) begin
                    state_next = FAULT;
                end else if (MEM_RDEN1) begin
                    if (memValid1) begin
                        push    = 1'b1;
                        pc_next = pc_reg + 32'd4;
                    end else begin
                        state_next = MISS;
                    end
                end
            end
            MISS: begin
                // A redirect coinciding with the refill needs no drain phase.
                if (PC_LOAD) begin
                    flush = 1'b1;
                    if (memValid1) begin
                        pc_next    = PC_TARGET;
                        state_next = FETCH;
                    end else begin
                        target_next = PC_TARGET;
                        state_next  = DRAIN;
                    end
                end else if (memValid1) begin
                    push       = 1'b1;
                    pc_next    = pc_reg + 32'd4;
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                if (PC_LOAD) begin
                    flush       = 1'b1;
                    target_next = PC_TARGET;
                end
                if (memValid1) begin
                    pc_next    = PC_LOAD ? PC_TARGET : target_reg;
                    state_next = FETCH;
                end
            end
            FAULT: begin
                if (PC_LOAD) begin
                    flush      = 1'b1;
                    pc_next    = PC_TARGET;
                    state_next = FETCH;
                end
            end
            default: state_next = RESET;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= RESET;
            pc_reg     <= RESET_PC;
            target_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            target_reg <= target_next;
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .srst      (RST),
        .flush     (flush),
        .push      (push),
        .push_data ({pc_reg, MEM_DOUT1}),
        .pop       (IF_VALID & ID_READY),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plan scenarios followed by random traffic, all checked each cycle
// against a queue-based model of the fetch front end.
module tb_instr_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        PC_LOAD = 1'b0;
    logic [31:0] PC_TARGET = '0;
    logic        ID_READY = 1'b0;
    logic        IF_VALID;
    logic [31:0] IF_INSTR;
    logic [31:0] IF_PC;
    logic        IF_FAULT;
    logic        MEM_RDEN1;
    logic [13:0] MEM_ADDR1;
    logic [31:0] MEM_DOUT1 = '0;
    logic        memValid1 = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    typedef enum {M_BOOT, M_RUN, M_WAIT, M_REDIR, M_HALT} mode_t;

    ent_t        q[$];
    mode_t       mode;
    logic [31:0] m_pc;
    logic [31:0] m_saved;

    instr_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PC_LOAD   (PC_LOAD),
        .PC_TARGET (PC_TARGET),
        .ID_READY  (ID_READY),
        .IF_VALID  (IF_VALID),
        .IF_INSTR  (IF_INSTR),
        .IF_PC     (IF_PC),
        .IF_FAULT  (IF_FAULT),
        .MEM_RDEN1 (MEM_RDEN1),
        .MEM_ADDR1 (MEM_ADDR1),
        .MEM_DOUT1 (MEM_DOUT1),
        .memValid1 (memValid1)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [13:0] a);
        return 32'hC0DE_0000 ^ {a, a, 4'h5};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, compare outputs, advance model.
    task automatic step(input logic rst, input logic pl, input logic [31:0] tgt,
                        input logic rdy, input logic mv);
        logic legal, rden, valid, flush;
        RST       = rst;
        PC_LOAD   = pl;
        PC_TARGET = tgt;
        ID_READY  = rdy;
        memValid1 = mv;
        MEM_DOUT1 = mem_word(MEM_ADDR1);
        #1;
        legal = (m_pc < 32'h6000) && (m_pc[1:0] == 2'b00);
        rden  = (mode == M_RUN && q.size() < DEPTH && legal) || mode == M_WAIT || mode == M_REDIR;
        valid = (q.size() > 0);
        check("if_valid", 32'(IF_VALID), 32'(valid));
        if (valid) begin
            check("if_pc", IF_PC, q[0].pc);
            check("if_instr", IF_INSTR, q[0].instr);
        end
        check("if_fault", 32'(IF_FAULT), 32'(mode == M_HALT));
        check("mem_rden1", 32'(MEM_RDEN1), 32'(rden));
        check("mem_addr1", 32'(MEM_ADDR1), 32'(m_pc[15:2]));

        flush = 1'b0;
        if (rst) begin
            mode = M_BOOT;
            m_pc = RESET_PC;
            q.delete();
        end else begin
            if (valid && rdy && !pl) void'(q.pop_front());
            case (mode)
                M_BOOT: mode = M_RUN;
                M_RUN: begin
                    if (pl) begin
                        flush = 1'b1;
                        m_pc  = tgt;
                    end else if (!legal) begin
                        mode = M_HALT;
                    end else if (rden) begin
                        if (mv) begin
                            q.push_back('{pc: m_pc, instr: mem_word(m_pc[15:2])});
                            m_pc = m_pc + 32'd4;
                        end else begin
                            mode = M_WAIT;
                        end
                    end
                end
                M_WAIT: begin
                    if (pl) begin
                        flush = 1'b1;
                        if (mv) begin
                            m_pc = tgt;
                            mode = M_RUN;
                        end else begin
                            m_saved = tgt;
                            mode    = M_REDIR;
                        end
                    end else if (mv) begin
                        q.push_back('{pc: m_pc, instr: mem_word(m_pc[15:2])});
                        m_pc = m_pc + 32'd4;
                        mode = M_RUN;
                    end
                end
                M_REDIR: begin
                    if (pl) begin
                        flush   = 1'b1;
                        m_saved = tgt;
                    end
                    if (mv) begin
                        m_pc = m_saved;
                        mode = M_RUN;
                    end
                end
                M_HALT: begin
                    if (pl) begin
                        flush = 1'b1;
                        m_pc  = tgt;
                        mode  = M_RUN;
                    end
                end
                default: mode = M_BOOT;
            endcase
            if (flush) q.delete();
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        logic        r_rst, r_pl, r_rdy, r_mv;
        logic [31:0] r_tgt;
        int          sel;
        mode    = M_BOOT;
        m_pc    = RESET_PC;
        m_saved = '0;
        @(posedge CLK);
        @(negedge CLK);
        step(1, 0, 0, 0, 0);

        // Hit streaming from reset.
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        check("stream_valid", 32'(IF_VALID), 32'd1);
        check("stream_pc0", IF_PC, 32'h0);
        step(0, 0, 0, 1, 1);
        check("stream_pc4", IF_PC, 32'h4);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);

        // Backpressure: two entries held, fetch stalls, nothing dropped on release.
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1);
        check("bp_head_pc", IF_PC, 32'h0);
        check("bp_rden_full", 32'(MEM_RDEN1), 32'd0);
        check("bp_addr", 32'(MEM_ADDR1), 32'd2);
        step(0, 0, 0, 1, 1);
        check("bp_release_pc4", IF_PC, 32'h4);
        step(0, 0, 0, 1, 1);
        check("bp_release_pc8", IF_PC, 32'h8);

        // Miss at 0x20 with the address held throughout.
        step(0, 1, 32'h20, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
        check("miss_addr", 32'(MEM_ADDR1), 32'h8);
        check("miss_rden", 32'(MEM_RDEN1), 32'd1);
        step(0, 0, 0, 1, 1);
        check("miss_pushed_pc", IF_PC, 32'h20);
        check("miss_next_addr", 32'(MEM_ADDR1), 32'h9);

        // Redirect to 0x100 during a miss at 0x40.
        step(0, 1, 32'h40, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 32'h100, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        check("drain_addr", 32'(MEM_ADDR1), 32'h10);
        step(0, 0, 0, 1, 1);
        check("drain_discard", 32'(IF_VALID), 32'd0);
        step(0, 0, 0, 1, 1);
        check("drain_target_pc", IF_PC, 32'h100);

        // Fault at the top of instruction memory, cleared by a redirect.
        step(0, 1, 32'h5FFC, 1, 1);
        step(0, 0, 0, 1, 1);
        check("bound_last_pc", IF_PC, 32'h5FFC);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        check("fault_set", 32'(IF_FAULT), 32'd1);
        check("fault_rden", 32'(MEM_RDEN1), 32'd0);
        step(0, 1, 32'h0, 1, 1);
        check("fault_cleared", 32'(IF_FAULT), 32'd0);

        // Reset while draining.
        step(0, 1, 32'h80, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 1, 32'h200, 1, 0);
        step(1, 0, 0, 1, 0);
        check("rst_valid", 32'(IF_VALID), 32'd0);
        check("rst_rden", 32'(MEM_RDEN1), 32'd0);
        check("rst_addr", 32'(MEM_ADDR1), 32'd0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_pl  = ($urandom_range(0, 7) == 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            r_mv  = ($urandom_range(0, 3) != 0);
            sel   = $urandom_range(0, 9);
            if (sel < 7)       r_tgt = 32'($urandom_range(0, 63)) << 2;
            else if (sel == 7) r_tgt = 32'h5FF0 + (32'($urandom_range(0, 5)) << 2);
            else if (sel == 8) r_tgt = 32'($urandom_range(0, 32'h5FFF));
            else               r_tgt = $urandom;
            step(r_rst, r_pl, r_tgt, r_rdy, r_mv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
